// File: rtl/tree_layer2_merge.sv
// tree_layer2_merge: groups CHILD layer-1 counters into one layer-2 node, writes its low field to RAM and forwards the residual.
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   In_Valid/In_Counter full 32-bit counter from layer 1, In_Last marks the frame's last counter
//   Ram_Wr_En/Addr/Data layer-2 RAM write port, one pulse per closed group
//   Out_Valid/Next_Counter residual (max >> L2_BITS) handed to layer 3, coincident with the write
//   Ovf_Count           saturating count of groups with a nonzero residual
//   Done                frame complete, held until Reset
module tree_layer2_merge #(
   parameter int NUM_COUNTER = 10,
   parameter int NUM_SLICE   = 3,
   parameter int CHILD       = 3,
   parameter int L1_BITS     = 3,
   parameter int L2_BITS     = 8,
   parameter int ADDR_W      = 7
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               In_Valid,
   input  logic [31:0]        In_Counter,
   input  logic               In_Last,
   output logic               Ram_Wr_En,
   output logic [ADDR_W-1:0]  Ram_Addr,
   output logic [L2_BITS-1:0] Ram_Data,
   output logic               Out_Valid,
   output logic [31:0]        Next_Counter,
   output logic [15:0]        Ovf_Count,
   output logic               Done
);
   localparam int NUM_GROUP = (NUM_COUNTER * NUM_SLICE + CHILD - 1) / CHILD;
   localparam int CW = $clog2(CHILD + 1);
   typedef enum logic {S_ACC, S_DONE} state_t;
   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [ADDR_W-1:0]  grp_q, grp_d, addr_q, addr_d;
   logic [31:0]        max_q, max_d, next_q, next_d, hi, m_new;
   logic [L2_BITS-1:0] data_q, data_d;
   logic [15:0]        ovf_q, ovf_d;
   logic               wr_q, wr_d, take, close;
   always_comb begin
      hi      = In_Counter >> L1_BITS;
      take    = In_Valid && state_q == S_ACC;
      // first member of a group loads the max instead of comparing against a stale one
      m_new   = (cnt_q == '0 || hi > max_q) ? hi : max_q;
      close   = take && (In_Last || cnt_q == CW'(CHILD - 1));
      state_d = state_q;
      cnt_d   = cnt_q;
      grp_d   = grp_q;
      max_d   = max_q;
      addr_d  = addr_q;
      data_d  = data_q;
      next_d  = next_q;
      ovf_d   = ovf_q;
      wr_d    = 1'b0;
      if (take) begin
         max_d = m_new;
         cnt_d = close ? '0 : cnt_q + CW'(1);
      end
      if (close) begin
         wr_d    = 1'b1;
         addr_d  = grp_q;
         data_d  = m_new[L2_BITS-1:0];
         next_d  = m_new >> L2_BITS;
         grp_d   = grp_q + ADDR_W'(1);
         ovf_d   = (next_d != '0 && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
         // the last legal address ends the frame, so the index never wraps
         state_d = (In_Last || grp_q == ADDR_W'(NUM_GROUP - 1)) ? S_DONE : S_ACC;
      end
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_ACC;
         cnt_q   <= '0;
         grp_q   <= '0;
         max_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         next_q  <= '0;
         ovf_q   <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grp_q   <= grp_d;
         max_q   <= max_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         next_q  <= next_d;
         ovf_q   <= ovf_d;
         wr_q    <= wr_d;
      end
   end
   assign Ram_Wr_En    = wr_q;
   assign Out_Valid    = wr_q;
   assign Ram_Addr     = addr_q;
   assign Ram_Data     = data_q;
   assign Next_Counter = next_q;
   assign Ovf_Count    = ovf_q;
   assign Done         = state_q == S_DONE;
endmodule
